// File: rtl/imem_stream_loader.sv
// Instruction memory with a post-reset clear sweep, a valid/ready load stream
// and a registered, fault-checked fetch port driven by the PC.
module imem_stream_loader #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH       = 1024,
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [DATA_W-1:0] CLEAR_VAL   = '0,
    parameter logic [DATA_W-1:0] FAULT_INSTR = DATA_W'(32'h0000_0013)
) (
    input  logic                     SYS_clk,
    input  logic                     SYS_reset,
    input  logic                     reload,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     load_valid,
    input  logic                     load_last,
    output logic                     load_ready,
    output logic [$clog2(DEPTH):0]   load_count,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_ready,
    output logic                     fetch_valid,
    output logic [DATA_W-1:0]        fetch_instr,
    output logic                     fetch_fault
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    typedef enum logic [1:0] {StClear, StLoad, StRun} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [IDX_W-1:0]  r_clr_idx;
    logic [CNT_W-1:0]  r_load_count;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_fetch_valid;
    logic              r_fetch_fault;
    logic [DATA_W-1:0] r_fetch_instr;

    logic              w_mem_we;
    logic [IDX_W-1:0]  w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic              w_load_acc;
    logic              w_load_rst;
    logic              w_fetch_go;
    logic              w_fetch_fault;
    logic [IDX_W-1:0]  w_fetch_idx;

    // Upper address bits are range-checked rather than dropped, so a wild PC faults.
    assign w_fetch_idx   = fetch_addr[IDX_W+1:2];
    assign w_fetch_fault = (fetch_addr[1:0] != 2'b00) || (fetch_addr[ADDR_W-1:IDX_W+2] != '0);
    assign w_fetch_go    = (r_state == StRun) && fetch_req;

    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        w_mem_waddr  = r_clr_idx;
        w_mem_wdata  = CLEAR_VAL;
        w_load_acc   = 1'b0;
        w_load_rst   = 1'b0;
        load_ready   = 1'b0;
        fetch_ready  = 1'b0;
        unique case (r_state)
            StClear: begin
                w_mem_we = 1'b1;
                if (r_clr_idx == IDX_W'(DEPTH - 1)) w_state_next = StLoad;
            end
            StLoad: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    w_load_acc  = 1'b1;
                    w_mem_we    = 1'b1;
                    w_mem_waddr = r_load_count[IDX_W-1:0];
                    w_mem_wdata = load_data;
                    // Leaving at the last index keeps further beats from wrapping.
                    if (load_last || (r_load_count == CNT_W'(DEPTH - 1))) w_state_next = StRun;
                end
            end
            StRun: begin
                fetch_ready = 1'b1;
                if (reload) begin
                    w_load_rst   = 1'b1;
                    w_state_next = StLoad;
                end
            end
            default: w_state_next = StClear;
        endcase
    end

    always_ff @(posedge SYS_clk) begin
        if (!SYS_reset) begin
            r_state       <= StClear;
            r_clr_idx     <= '0;
            r_load_count  <= '0;
            r_fetch_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
            r_fetch_instr <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == StClear) r_clr_idx <= r_clr_idx + IDX_W'(1);
            if (w_load_rst) begin
                r_load_count <= '0;
            end else if (w_load_acc) begin
                r_load_count <= r_load_count + CNT_W'(1);
            end
            r_fetch_valid <= w_fetch_go;
            if (w_fetch_go) begin
                r_fetch_fault <= w_fetch_fault;
                r_fetch_instr <= w_fetch_fault ? FAULT_INSTR : r_mem[w_fetch_idx];
            end
        end
    end

    always_ff @(posedge SYS_clk) begin
        if (w_mem_we) r_mem[w_mem_waddr] <= w_mem_wdata;
    end

    assign load_count  = r_load_count;
    assign fetch_valid = r_fetch_valid;
    assign fetch_instr = r_fetch_instr;
    assign fetch_fault = r_fetch_fault;

endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboard bench for imem_stream_loader (DEPTH=16, ADDR_W=40): fetch responses
// are queued at issue time and checked by an independent monitor.
module tb_imem_stream_loader;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned ADDR_W = 40;

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
        logic [31:0] cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              reload = 1'b0;
    logic [DATA_W-1:0] load_data = '0;
    logic              load_valid = 1'b0;
    logic              load_last = 1'b0;
    logic              load_ready;
    logic [4:0]        load_count;
    logic              fetch_req = 1'b0;
    logic [ADDR_W-1:0] fetch_addr = '0;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_instr;
    logic              fetch_fault;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] cyc      = '0;
    exp_t        exp_q[$];

    imem_stream_loader #(
        .DATA_W     (DATA_W),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .CLEAR_VAL  (32'h0000_0000),
        .FAULT_INSTR(32'h0000_0013)
    ) dut (
        .SYS_clk    (clk),
        .SYS_reset  (rst_n),
        .reload     (reload),
        .load_data  (load_data),
        .load_valid (load_valid),
        .load_last  (load_last),
        .load_ready (load_ready),
        .load_count (load_count),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ready(fetch_ready),
        .fetch_valid(fetch_valid),
        .fetch_instr(fetch_instr),
        .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every valid response must match the oldest queued expectation.
    always @(negedge clk) begin
        if (fetch_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_fetch_valid", 64'(fetch_valid), 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("fetch_instr", 64'(fetch_instr), 64'(e.instr));
                chk("fetch_fault", 64'(fetch_fault), 64'(e.fault));
                chk("fetch_latency", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one fetch for one cycle; back-to-back calls keep fetch_req high.
    task automatic fetch(input logic [ADDR_W-1:0] a, input logic [31:0] ei, input logic ef);
        exp_t e;
        fetch_req  = 1'b1;
        fetch_addr = a;
        e.instr = ei;
        e.fault = ef;
        e.cyc   = cyc + 1;
        exp_q.push_back(e);
        step();
        fetch_req = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // Returns the number of cycles both ready outputs stayed low (bounded).
    task automatic wait_clear(output int n);
        n = 0;
        while (!load_ready && !fetch_ready && n < 64) begin
            n++;
            step();
        end
    endtask

    initial begin
        int n;
        int acc;
        int run_at;

        // 1: reset held two cycles, then a 16-cycle clear sweep.
        step();
        step();
        chk("reset_load_ready", 64'(load_ready), 64'd0);
        chk("reset_fetch_valid", 64'(fetch_valid), 64'd0);
        chk("reset_load_count", 64'(load_count), 64'd0);
        rst_n = 1'b1;
        fetch_req  = 1'b1;  // ignored outside RUN
        fetch_addr = '0;
        wait_clear(n);
        fetch_req = 1'b0;
        chk("clear_cycles", 64'(n), 64'd16);
        chk("load_ready_after_clear", 64'(load_ready), 64'd1);
        chk("fetch_ready_in_load", 64'(fetch_ready), 64'd0);

        // 2: three-word program, then back-to-back fetches.
        beat(32'h0050_0093, 1'b0);
        beat(32'h00A0_0113, 1'b0);
        beat(32'h0020_81B3, 1'b1);
        chk("run_fetch_ready", 64'(fetch_ready), 64'd1);
        chk("run_load_ready", 64'(load_ready), 64'd0);
        chk("load_count_3", 64'(load_count), 64'd3);
        fetch(40'h0, 32'h0050_0093, 1'b0);
        fetch(40'h4, 32'h00A0_0113, 1'b0);
        fetch(40'h8, 32'h0020_81B3, 1'b0);
        fetch(40'hC, 32'h0000_0000, 1'b0);
        step();

        // 3: misaligned and out-of-range fetches fault; outputs hold when idle.
        fetch(40'h6, 32'h0000_0013, 1'b1);
        fetch(40'h40, 32'h0000_0013, 1'b1);
        fetch(40'h1_0000_0000, 32'h0000_0013, 1'b1);
        step();
        chk("idle_valid", 64'(fetch_valid), 64'd0);
        chk("idle_hold_instr", 64'(fetch_instr), 64'h13);
        chk("idle_hold_fault", 64'(fetch_fault), 64'd1);

        // 6: reload with a concurrent fetch, then overwrite word 0 only.
        reload = 1'b1;
        fetch(40'h4, 32'h00A0_0113, 1'b0);
        reload = 1'b0;
        chk("reload_load_ready", 64'(load_ready), 64'd1);
        chk("reload_count_zero", 64'(load_count), 64'd0);
        beat(32'h1111_1111, 1'b1);
        chk("reload_count_1", 64'(load_count), 64'd1);
        fetch(40'h0, 32'h1111_1111, 1'b0);
        fetch(40'h4, 32'h00A0_0113, 1'b0);
        fetch(40'h8, 32'h0020_81B3, 1'b0);
        step();

        // 4: 20-word stream without load_last; only 16 accepted.
        reload = 1'b1;
        step();
        reload = 1'b0;
        acc = 0;
        run_at = -1;
        for (int i = 0; i < 20; i++) begin
            if (load_ready) acc++;
            beat(32'h100 + 32'(i), 1'b0);
            if (fetch_ready && run_at < 0) run_at = i;
        end
        chk("overflow_accepted", 64'(acc), 64'd16);
        chk("overflow_run_after", 64'(run_at), 64'd15);
        chk("overflow_load_ready", 64'(load_ready), 64'd0);
        chk("overflow_count", 64'(load_count), 64'd16);
        fetch(40'h3C, 32'h10F, 1'b0);
        fetch(40'h0, 32'h100, 1'b0);
        step();

        // 5: reset mid-load, full clear, then a single-word load.
        reload = 1'b1;
        step();
        reload = 1'b0;
        beat(32'hAAAA_0000, 1'b0);
        beat(32'hAAAA_0001, 1'b0);
        chk("midload_count", 64'(load_count), 64'd2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midreset_count", 64'(load_count), 64'd0);
        chk("midreset_load_ready", 64'(load_ready), 64'd0);
        chk("midreset_fetch_ready", 64'(fetch_ready), 64'd0);
        wait_clear(n);
        chk("clear_cycles_2", 64'(n), 64'd16);
        beat(32'hDEAD_BEEF, 1'b1);
        fetch(40'h0, 32'hDEAD_BEEF, 1'b0);
        fetch(40'h4, 32'h0000_0000, 1'b0);
        fetch(40'h3C, 32'h0000_0000, 1'b0);
        step();
        step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

// File: doc/imem_stream_loader.md
Name: imem_stream_loader

Overview:
Parametrised instruction memory for the RISC-V core that replaces file-based preload with a hardware loading path.
- After reset, a sequential clear sweep zeroes the array.
- A valid/ready stream from the host/boot path then writes program words.
- The fetch port serves byte-addressed, registered one-cycle reads with alignment and range fault reporting.
- Sits between the boot loader and the IF stage; the PC drives the fetch port directly.

Parameters:
DATA_W, 32, instruction word width in bits
DEPTH, 1024, number of words stored; must be a power of two, at least 4
ADDR_W, 32, byte-address width of fetch_addr
CLEAR_VAL, 32'h0000_0000, value written to every word during the clear sweep
FAULT_INSTR, 32'h0000_0013, word returned on a faulting fetch (NOP: addi x0,x0,0)

Ports:
SYS_clk  in  1  clock; all state updates on its rising edge
SYS_reset  in  1  synchronous reset, active-low: state resets when SYS_reset==0 at a rising edge of SYS_clk
reload  in  1  single-cycle pulse; in RUN, starts a new load from word 0 (no clear)
load_data  in  DATA_W  program word to be written
load_valid  in  1  load_data is valid this cycle
load_last  in  1  qualifies the final word of the load stream
load_ready  out  1  block accepts a load word this cycle
load_count  out  $clog2(DEPTH)+1  number of words written since the last load start
fetch_req  in  1  fetch request
fetch_addr  in  ADDR_W  byte address (PC)
fetch_ready  out  1  block is in RUN and serves fetches
fetch_valid  out  1  registered response valid
fetch_instr  out  DATA_W  fetched word
fetch_fault  out  1  response faulted (misaligned or out of range)

Behaviour:
- FSM states: CLEAR, LOAD, RUN.
- Reset (SYS_reset==0 at a rising edge), from any state including mid-load or mid-fetch:
  - state<=CLEAR; clear index<=0; load_count<=0.
  - fetch_valid<=0, fetch_fault<=0, fetch_instr<=0.
  - load_ready and fetch_ready read 0 (combinational from state).
- CLEAR:
  - Writes CLEAR_VAL to mem[idx] each cycle; idx increments by 1.
  - After the write of idx==DEPTH-1 -> LOAD. CLEAR lasts exactly DEPTH cycles.
  - load_valid, fetch_req and reload are ignored.
- LOAD:
  - load_ready=1. A beat is accepted when load_valid && load_ready.
  - Accepted beat: mem[load_count]<=load_data; load_count<=load_count+1.
  - Exit to RUN on the cycle a beat with load_last=1 is accepted, or when the beat at index DEPTH-1 is accepted (overflow guard; later beats never wrap).
  - load_valid=0 leaves state unchanged. fetch_req is ignored.
- RUN:
  - fetch_ready=1, load_ready=0.
  - reload=1 -> LOAD next cycle with load_count<=0; memory contents are kept.
  - A fetch_req in the same cycle as reload is still served.
- Fetch, issued in RUN with fetch_req=1 in cycle N; response in cycle N+1:
  - fetch_valid=1.
  - Word index = fetch_addr>>2.
  - Fault if fetch_addr[1:0]!=0 OR fetch_addr>>2 >= DEPTH (upper bits are checked, never truncated).
  - No fault: fetch_instr=mem[index], fetch_fault=0.
  - Fault: fetch_instr=FAULT_INSTR, fetch_fault=1.
  - Back-to-back requests are accepted every cycle (throughput 1/cycle).
  - With no request, fetch_valid=0 next cycle; fetch_instr and fetch_fault hold their last values.
- fetch_req outside RUN produces no response (fetch_valid=0).
- Read-during-write cannot occur: write and fetch paths are exclusive by state.
- load_count saturates at DEPTH and stays readable in RUN.

Test Plan:
1. DEPTH=16: hold SYS_reset=0 for 2 cycles, release -> fetch_ready=0 and load_ready=0 for exactly 16 cycles, then load_ready=1.
2. Load 0x00500093, 0x00A00113, 0x002081B3 (last on the third) -> RUN, load_count=3. Fetches 0x0, 0x4, 0x8, 0xC -> 0x00500093, 0x00A00113, 0x002081B3, 0x00000000, one per cycle, each one cycle after its request, fault=0.
3. In RUN, fetch 0x6 -> fetch_instr=0x00000013, fault=1. Fetch 0x40 with DEPTH=16 -> 0x00000013, fault=1. Fetch 0x1_0000_0000 with ADDR_W=40 -> fault=1.
4. Stream 20 words with no load_last, DEPTH=16 -> 16 accepted, RUN entered after word 15, load_ready=0 afterwards, load_count=16.
5. Drive SYS_reset=0 mid-load after 2 beats -> next cycle state CLEAR, load_count=0. After the sweep, fetch 0x0 in RUN (after a load_last beat of 0xDEADBEEF at index 0) returns 0xDEADBEEF, and 0x4 returns 0x0.
6. reload pulse in RUN, then load 0x11111111 with load_last -> fetch 0x0 returns 0x11111111; fetch 0x4 still returns the prior contents.
